// File: rtl/div_wb_arbiter_if.sv
// Writeback-merge bus: ALU and divider result streams in, register-file write port and FIFO status out.
// Latency: n/a (signal bundle only).
// Backpressure: none; the divider side relies on div_full/pend_cnt for upstream stalling. Optional DIV_WB_FWD_EN adds fwd_* signals.
interface div_wb_arbiter_if #(
    parameter int CNT_W = 2
);
    logic             alu_wb_valid;
    logic [4:0]       alu_wb_rd;
    logic [63:0]      alu_wb_data;
    logic             div_valid;
    logic [4:0]       div_rd;
    logic [63:0]      div_data;
    logic             wb_en;
    logic [4:0]       wb_rd;
    logic [63:0]      wb_data;
    logic             div_full;
    logic [CNT_W-1:0] pend_cnt;
    logic             div_ovf;
`ifdef DIV_WB_FWD_EN
    logic [4:0]       fwd_rd;
    logic             fwd_hit;
    logic [63:0]      fwd_data;
`endif

    // Arbiter side
    modport slave (
`ifdef DIV_WB_FWD_EN
        input  fwd_rd,
        output fwd_hit, fwd_data,
`endif
        input  alu_wb_valid, alu_wb_rd, alu_wb_data,
        input  div_valid, div_rd, div_data,
        output wb_en, wb_rd, wb_data,
        output div_full, pend_cnt, div_ovf
    );

    // Producer / consumer side
    modport master (
`ifdef DIV_WB_FWD_EN
        output fwd_rd,
        input  fwd_hit, fwd_data,
`endif
        output alu_wb_valid, alu_wb_rd, alu_wb_data,
        output div_valid, div_rd, div_data,
        input  wb_en, wb_rd, wb_data,
        input  div_full, pend_cnt, div_ovf
    );
endinterface

// File: rtl/div_wb_arbiter.sv
// Merges ALU and divider results onto one register-file write port; ALU wins, colliding divider results park in a FIFO.
// Latency: 1 cycle from selection to wb_*; divider results retire in arrival order.
// Backpressure: none accepted; a divider result arriving with the FIFO full and no pop is dropped and div_ovf sticks. Optional macro DIV_WB_FWD_EN adds a parked-result forwarding search.
module div_wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input logic             clk,
    input logic             rst_n,
    div_wb_arbiter_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
    } ent_t;

    ent_t             mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wb_en_q, wb_en_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic [63:0]      wb_data_q, wb_data_d;
    logic             ovf_q, ovf_d;

    logic alu_ok, div_ok, fifo_empty, fifo_full;
    logic push_req, push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign alu_ok     = bus.alu_wb_valid && (bus.alu_wb_rd != 5'd0);
    assign div_ok     = bus.div_valid && (bus.div_rd != 5'd0);
    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CNT_W'(DEPTH));

    // Priority select (ALU > FIFO head > divider bypass) and FIFO bookkeeping
    always_comb begin
        wb_en_d   = 1'b0;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        push_req  = 1'b0;
        pop       = 1'b0;
        if (alu_ok) begin
            wb_en_d   = 1'b1;
            wb_rd_d   = bus.alu_wb_rd;
            wb_data_d = bus.alu_wb_data;
            push_req  = div_ok;
        end else if (!fifo_empty) begin
            pop       = 1'b1;
            wb_en_d   = 1'b1;
            wb_rd_d   = mem_q[rd_ptr_q].rd;
            wb_data_d = mem_q[rd_ptr_q].data;
            push_req  = div_ok;
        end else if (div_ok) begin
            // Bypass only with an empty FIFO, so arrival order is preserved
            wb_en_d   = 1'b1;
            wb_rd_d   = bus.div_rd;
            wb_data_d = bus.div_data;
        end
        // A full FIFO still accepts a push when the head leaves in the same cycle
        push     = push_req && (!fifo_full || pop);
        ovf_d    = ovf_q || (push_req && !push);
        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    end

    // Control and writeback registers; reset discards anything queued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            cnt_q     <= '0;
            wb_en_q   <= 1'b0;
            wb_rd_q   <= 5'd0;
            wb_data_q <= 64'd0;
            ovf_q     <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            cnt_q     <= cnt_d;
            wb_en_q   <= wb_en_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            ovf_q     <= ovf_d;
        end
    end

    // FIFO storage; contents are only meaningful below cnt_q, so no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{rd: bus.div_rd, data: bus.div_data};
        end
    end

    assign bus.wb_en    = wb_en_q;
    assign bus.wb_rd    = wb_rd_q;
    assign bus.wb_data  = wb_data_q;
    assign bus.div_full = fifo_full;
    assign bus.pend_cnt = cnt_q;
    assign bus.div_ovf  = ovf_q;

`ifdef DIV_WB_FWD_EN
    logic [PTR_W-1:0] fwd_idx;
    logic             fwd_hit_c;
    logic [63:0]      fwd_data_c;

    // Walk entries oldest to youngest so the youngest match is the one left standing
    always_comb begin
        fwd_idx    = '0;
        fwd_hit_c  = 1'b0;
        fwd_data_c = 64'd0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < cnt_q) && (bus.fwd_rd != 5'd0) &&
                (mem_q[fwd_idx].rd == bus.fwd_rd)) begin
                fwd_hit_c  = 1'b1;
                fwd_data_c = mem_q[fwd_idx].data;
            end
        end
    end

    assign bus.fwd_hit  = fwd_hit_c;
    assign bus.fwd_data = fwd_data_c;
`endif
endmodule
